pedestrian_controller: RTL and testbench

PEDESTRIAN_CONTROLLER -- requirements
Module: pedestrian_controller

---
 rtl/traffic_pkg.sv | 38 +++
 rtl/tick_timer.sv | 32 +++
 rtl/pedestrian_controller.sv | 129 ++++++++++++
 tb/tb_pedestrian_controller.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared types and light codes for the pedestrian crossing controller.
package traffic_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [2:0] {
    ST_CAR_GREEN  = 3'd0,
    ST_CAR_YELLOW = 3'd1,
    ST_RED_PRE    = 3'd2,
    ST_WALK       = 3'd3,
    ST_FLASH      = 3'd4,
    ST_RED_POST   = 3'd5
  } ctrl_state_e;

  // walk display codes {walk, flashing_dont_walk, dont_walk}
  localparam logic [2:0] W_OFF              = 3'b000;
  localparam logic [2:0] W_DONTWALK         = 3'b001;
  localparam logic [2:0] W_FLASHINGDONTWALK = 3'b010;
  localparam logic [2:0] W_WALK             = 3'b100;

  // car light codes {red, yellow, green}
  localparam logic [2:0] C_RED    = 3'b100;
  localparam logic [2:0] C_YELLOW = 3'b010;
  localparam logic [2:0] C_GREEN  = 3'b001;

  // Everything the controller drives, registered as one bundle.
  typedef struct packed {
    logic [2:0] car;
    logic [2:0] walk;
    logic       blink;
  } lamp_t;

  // Durations must fit the 8-bit timer and be at least one tick.
  function automatic logic dur_ok(input int v);
    return (v >= 1) && (v <= 255);
  endfunction

endpackage

// File: rtl/tick_timer.sv
// Loadable 8-bit down-counter advanced by the tick enable; saturates at zero.
module tick_timer
  import traffic_pkg::*;
#(
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             tick,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Load wins over counting; counting stops once zero is reached.
  always_comb begin
    cnt_d = cnt_q;
    if (load)                     cnt_d = load_val;
    else if (tick && cnt_q != '0) cnt_d = cnt_q - 1'b1;
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= RST_VAL;
    else          cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/pedestrian_controller.sv
// Pedestrian crossing controller: car lights plus walk display, tick-timed.
module pedestrian_controller
  import traffic_pkg::*;
#(
  parameter int GREEN_MIN    = 10,
  parameter int YELLOW_TIME  = 3,
  parameter int ALL_RED_TIME = 1,
  parameter int WALK_TIME    = 8,
  parameter int FLASH_TIME   = 6
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick,
  input  logic       walk_request,
  output logic [2:0] walk_state,
  output logic [2:0] car_light,
  output logic       blink
);

  generate
    if (!dur_ok(GREEN_MIN) || !dur_ok(YELLOW_TIME) || !dur_ok(ALL_RED_TIME) ||
        !dur_ok(WALK_TIME) || !dur_ok(FLASH_TIME)) begin : g_bad_param
      $error("pedestrian_controller: every duration must be in 1..255");
    end
  endgenerate

  // Counter reload values are duration-1 so a state spans exactly its duration.
  localparam logic [CNT_W-1:0] LD_GREEN  = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] LD_YELLOW = CNT_W'(YELLOW_TIME - 1);
  localparam logic [CNT_W-1:0] LD_RED    = CNT_W'(ALL_RED_TIME - 1);
  localparam logic [CNT_W-1:0] LD_WALK   = CNT_W'(WALK_TIME - 1);
  localparam logic [CNT_W-1:0] LD_FLASH  = CNT_W'(FLASH_TIME - 1);

  localparam lamp_t LAMP_RST = '{car: C_GREEN, walk: W_DONTWALK, blink: 1'b1};

  ctrl_state_e      state_q, state_d;
  logic             pending_q, pending_d;
  lamp_t            lamp_q, lamp_d;
  logic             tmr_zero;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             enter_walk;

  tick_timer #(.RST_VAL(LD_GREEN)) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tick     (tick),
    .zero     (tmr_zero)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_CAR_GREEN;
    else          state_q <= state_d;
  end

  // Next state: every move happens on a tick with the timer expired.
  always_comb begin
    state_d = state_q;
    if (tick && tmr_zero) begin
      case (state_q)
        ST_CAR_GREEN:  if (pending_q || walk_request) state_d = ST_CAR_YELLOW;
        ST_CAR_YELLOW: state_d = ST_RED_PRE;
        ST_RED_PRE:    state_d = ST_WALK;
        ST_WALK:       state_d = ST_FLASH;
        ST_FLASH:      state_d = ST_RED_POST;
        ST_RED_POST:   state_d = ST_CAR_GREEN;
        default:       state_d = ST_CAR_GREEN;
      endcase
    end
  end

  // Reload the timer with the entered state's duration on every state change.
  always_comb begin
    tmr_load = (state_d != state_q);
    case (state_d)
      ST_CAR_YELLOW:           tmr_val = LD_YELLOW;
      ST_RED_PRE, ST_RED_POST: tmr_val = LD_RED;
      ST_WALK:                 tmr_val = LD_WALK;
      ST_FLASH:                tmr_val = LD_FLASH;
      default:                 tmr_val = LD_GREEN;
    endcase
  end

  // Request latch: ignored while walking, consumed by entering WALK.
  assign enter_walk = (state_d == ST_WALK) && (state_q != ST_WALK);

  always_comb begin
    pending_d = pending_q;
    if (walk_request && state_q != ST_WALK) pending_d = 1'b1;
    if (enter_walk)                         pending_d = 1'b0;
  end

  // Pending register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pending_q <= 1'b0;
    else          pending_q <= pending_d;
  end

  // Output decode from the next state so the registered lamps move with it.
  always_comb begin
    lamp_d = LAMP_RST;
    case (state_d)
      ST_CAR_GREEN:  begin lamp_d.car = C_GREEN;  lamp_d.walk = W_DONTWALK;         end
      ST_CAR_YELLOW: begin lamp_d.car = C_YELLOW; lamp_d.walk = W_DONTWALK;         end
      ST_RED_PRE:    begin lamp_d.car = C_RED;    lamp_d.walk = W_DONTWALK;         end
      ST_WALK:       begin lamp_d.car = C_RED;    lamp_d.walk = W_WALK;             end
      ST_FLASH:      begin lamp_d.car = C_RED;    lamp_d.walk = W_FLASHINGDONTWALK; end
      ST_RED_POST:   begin lamp_d.car = C_RED;    lamp_d.walk = W_DONTWALK;         end
      default:       begin lamp_d.car = C_GREEN;  lamp_d.walk = W_DONTWALK;         end
    endcase
    // blink starts high on FLASH entry and toggles per tick while staying.
    if (state_d == ST_FLASH && state_q == ST_FLASH)
      lamp_d.blink = tick ? ~lamp_q.blink : lamp_q.blink;
  end

  // Output register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) lamp_q <= LAMP_RST;
    else          lamp_q <= lamp_d;
  end

  assign car_light  = lamp_q.car;
  assign walk_state = lamp_q.walk;
  assign blink      = lamp_q.blink;

endmodule

// File: tb/tb_pedestrian_controller.sv
// Directed bench for pedestrian_controller with short durations.
module tb_pedestrian_controller;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       tick = 1'b0;
  logic       walk_request = 1'b0;
  logic [2:0] walk_state;
  logic [2:0] car_light;
  logic       blink;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    bit         req;
    logic [2:0] car;
    logic [2:0] wk;
    bit         bl;
  } vec_t;

  vec_t vecs[20];

  always #5 clk = ~clk;

  pedestrian_controller #(
    .GREEN_MIN(4), .YELLOW_TIME(2), .ALL_RED_TIME(1), .WALK_TIME(3), .FLASH_TIME(4)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .tick         (tick),
    .walk_request (walk_request),
    .walk_state   (walk_state),
    .car_light    (car_light),
    .blink        (blink)
  );

  task automatic check(input string nm, input logic [2:0] car, input logic [2:0] wk, input logic bl);
    n_tests++;
    if (car_light !== car || walk_state !== wk || blink !== bl) begin
      n_fail++;
      $display("FAIL %s: got car=%b walk=%b blink=%b, expected car=%b walk=%b blink=%b",
               nm, car_light, walk_state, blink, car, wk, bl);
    end
  endtask

  // One clk cycle with the given tick/request levels; samples 1ns after the edge.
  task automatic cycle(input bit t, input bit r);
    @(negedge clk);
    tick = t;
    walk_request = r;
    @(posedge clk);
    #1;
    tick = 1'b0;
    walk_request = 1'b0;
  endtask

  // Single-cycle tick followed by one quiet cycle.
  task automatic tick_once(input bit r);
    cycle(1'b1, r);
    cycle(1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check("reset", 3'b001, 3'b001, 1'b1);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    // Per-tick expectations after reset with a request on tick 1.
    vecs[0]  = '{1'b1, 3'b001, 3'b001, 1'b1};
    vecs[1]  = '{1'b0, 3'b001, 3'b001, 1'b1};
    vecs[2]  = '{1'b0, 3'b001, 3'b001, 1'b1};
    vecs[3]  = '{1'b0, 3'b010, 3'b001, 1'b1};
    vecs[4]  = '{1'b0, 3'b010, 3'b001, 1'b1};
    vecs[5]  = '{1'b0, 3'b100, 3'b001, 1'b1};
    vecs[6]  = '{1'b0, 3'b100, 3'b100, 1'b1};
    vecs[7]  = '{1'b0, 3'b100, 3'b100, 1'b1};
    vecs[8]  = '{1'b0, 3'b100, 3'b100, 1'b1};
    vecs[9]  = '{1'b0, 3'b100, 3'b010, 1'b1};
    vecs[10] = '{1'b0, 3'b100, 3'b010, 1'b0};
    vecs[11] = '{1'b0, 3'b100, 3'b010, 1'b1};
    vecs[12] = '{1'b0, 3'b100, 3'b010, 1'b0};
    vecs[13] = '{1'b0, 3'b100, 3'b001, 1'b1};
    vecs[14] = '{1'b0, 3'b001, 3'b001, 1'b1};
    vecs[15] = '{1'b0, 3'b001, 3'b001, 1'b1};
    vecs[16] = '{1'b0, 3'b001, 3'b001, 1'b1};
    vecs[17] = '{1'b0, 3'b001, 3'b001, 1'b1};
    vecs[18] = '{1'b0, 3'b001, 3'b001, 1'b1};
    vecs[19] = '{1'b0, 3'b001, 3'b001, 1'b1};

    // Idle: green forever, then a request coinciding with the exit tick.
    do_reset();
    for (int i = 1; i <= 50; i++) begin
      tick_once(1'b0);
      check($sformatf("idle t%0d", i), 3'b001, 3'b001, 1'b1);
    end
    tick_once(1'b1);
    check("req on exit tick", 3'b010, 3'b001, 1'b1);

    // Full crossing cycle; each tick is also followed by a quiet-cycle hold check.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, vecs[i].req);
      check($sformatf("seq t%0d", i + 1), vecs[i].car, vecs[i].wk, vecs[i].bl);
      cycle(1'b0, 1'b0);
      check($sformatf("seq hold t%0d", i + 1), vecs[i].car, vecs[i].wk, vecs[i].bl);
    end

    // Requests during WALK are dropped.
    do_reset();
    tick_once(1'b1);
    for (int i = 2; i <= 7; i++) tick_once(1'b0);
    check("walk entered", 3'b100, 3'b100, 1'b1);
    cycle(1'b0, 1'b1);
    for (int i = 8; i <= 15; i++) tick_once(i == 8);
    check("green after walk", 3'b001, 3'b001, 1'b1);
    for (int i = 16; i <= 35; i++) begin
      tick_once(1'b0);
      check($sformatf("no rewalk t%0d", i), 3'b001, 3'b001, 1'b1);
    end

    // Request during FLASH: served after a full green.
    do_reset();
    tick_once(1'b1);
    for (int i = 2; i <= 10; i++) tick_once(1'b0);
    check("flash entered", 3'b100, 3'b010, 1'b1);
    tick_once(1'b1);
    for (int i = 12; i <= 15; i++) tick_once(1'b0);
    check("green reentry", 3'b001, 3'b001, 1'b1);
    for (int i = 16; i <= 22; i++) begin
      tick_once(1'b0);
      if (i <= 18)      check($sformatf("rewalk t%0d", i), 3'b001, 3'b001, 1'b1);
      else if (i <= 20) check($sformatf("rewalk t%0d", i), 3'b010, 3'b001, 1'b1);
      else if (i == 21) check($sformatf("rewalk t%0d", i), 3'b100, 3'b001, 1'b1);
      else              check($sformatf("rewalk t%0d", i), 3'b100, 3'b100, 1'b1);
    end

    // Asynchronous reset in the middle of WALK.
    do_reset();
    tick_once(1'b1);
    for (int i = 2; i <= 8; i++) tick_once(1'b0);
    check("mid walk", 3'b100, 3'b100, 1'b1);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check("async reset", 3'b001, 3'b001, 1'b1);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick_once(1'b0);
      check($sformatf("post reset t%0d", i), 3'b001, 3'b001, 1'b1);
    end

    // First tick after reset counts; a request on a quiet cycle is latched.
    do_reset();
    for (int i = 1; i <= 3; i++) tick_once(1'b0);
    check("count t3", 3'b001, 3'b001, 1'b1);
    cycle(1'b0, 1'b1);
    check("quiet req holds", 3'b001, 3'b001, 1'b1);
    tick_once(1'b0);
    check("pending t4", 3'b010, 3'b001, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
